// File: rtl/crtc_timing.sv
// MC6845-style raster timing generator: derives HSYNC, VSYNC, display enable,
// video memory address and scan-line address from the live CRTC register values.
module crtc_timing #(
  parameter int MA_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                char_clk_en,
  input  logic [7:0]          h_total,
  input  logic [7:0]          h_displayed,
  input  logic [7:0]          h_sync_pos,
  input  logic [3:0]          h_sync_width,
  input  logic [3:0]          v_sync_width,
  input  logic [6:0]          v_total,
  input  logic [4:0]          v_line_adjust,
  input  logic [6:0]          v_displayed,
  input  logic [6:0]          v_sync_pos,
  input  logic [4:0]          char_height,
  input  logic [13:0]         start_addr,
  output logic                h_sync,
  output logic                v_sync,
  output logic                display_en,
  output logic [MA_WIDTH-1:0] ma,
  output logic [4:0]          ra,
  output logic                frame_start
);

  typedef enum logic {ACTIVE_ROWS, ADJUST} vstate_t;

  vstate_t               vstate, n_state;
  logic                  started;
  logic [7:0]            h_count, n_h;
  logic [6:0]            row, n_row;
  logic [4:0]            n_ra;
  logic [MA_WIDTH-1:0]   row_base, n_base;
  logic [4:0]            hs_rem, n_hs, vs_rem, n_vs;
  logic                  new_frame, new_line;
  logic [4:0]            hs_w, vs_w;

  // A width field of 0 means 16.
  assign hs_w = {(h_sync_width == 4'd0), h_sync_width};
  assign vs_w = {(v_sync_width == 4'd0), v_sync_width};

  always_comb begin
    n_h       = h_count;
    n_ra      = ra;
    n_row     = row;
    n_state   = vstate;
    n_base    = row_base;
    new_frame = 1'b0;
    new_line  = 1'b0;
    if (!started) begin
      new_frame = 1'b1;
      new_line  = 1'b1;
    end else if (h_count == h_total) begin
      n_h      = 8'd0;
      new_line = 1'b1;
      if (vstate == ACTIVE_ROWS) begin
        if (ra == char_height) begin
          n_ra   = 5'd0;
          n_row  = row + 7'd1;
          n_base = row_base + MA_WIDTH'(h_displayed);
          if (row == v_total) begin
            if (v_line_adjust != 5'd0) n_state = ADJUST;
            else                       new_frame = 1'b1;
          end
        end else begin
          n_ra = ra + 5'd1;
        end
      end else begin
        // Adjust lines reuse ra as their counter, starting at 0.
        if ((ra + 5'd1) >= v_line_adjust) new_frame = 1'b1;
        else                              n_ra = ra + 5'd1;
      end
    end else begin
      n_h = h_count + 8'd1;
    end
    if (new_frame) begin
      n_h     = 8'd0;
      n_ra    = 5'd0;
      n_row   = 7'd0;
      n_state = ACTIVE_ROWS;
      n_base  = MA_WIDTH'(start_addr);
    end

    if (n_h == h_sync_pos)   n_hs = hs_w;
    else if (hs_rem != 5'd0) n_hs = hs_rem - 5'd1;
    else                     n_hs = 5'd0;

    // VSYNC is counted in lines, so it only moves at a line boundary.
    n_vs = vs_rem;
    if (new_line) begin
      if (n_row == v_sync_pos && n_ra == 5'd0 && n_state == ACTIVE_ROWS) n_vs = vs_w;
      else if (vs_rem != 5'd0)                                           n_vs = vs_rem - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vstate      <= ACTIVE_ROWS;
      started     <= 1'b0;
      h_count     <= '0;
      row         <= '0;
      ra          <= '0;
      row_base    <= '0;
      hs_rem      <= '0;
      vs_rem      <= '0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      display_en  <= 1'b0;
      ma          <= '0;
      frame_start <= 1'b0;
    end else if (char_clk_en) begin
      vstate      <= n_state;
      started     <= 1'b1;
      h_count     <= n_h;
      row         <= n_row;
      ra          <= n_ra;
      row_base    <= n_base;
      hs_rem      <= n_hs;
      vs_rem      <= n_vs;
      h_sync      <= (n_hs != 5'd0);
      v_sync      <= (n_vs != 5'd0);
      display_en  <= (n_h < h_displayed) && (n_row < v_displayed) && (n_state == ACTIVE_ROWS);
      ma          <= n_base + MA_WIDTH'(n_h);
      frame_start <= new_frame;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crtc_timing.sv
// Randomized bench for crtc_timing against a line/frame arithmetic model.
module tb_crtc_timing;
  logic        clk = 1'b0;
  logic        reset, char_clk_en;
  logic [7:0]  h_total, h_displayed, h_sync_pos;
  logic [3:0]  h_sync_width, v_sync_width;
  logic [6:0]  v_total, v_displayed, v_sync_pos;
  logic [4:0]  v_line_adjust, char_height;
  logic [13:0] start_addr;
  logic        h_sync, v_sync, display_en, frame_start;
  logic [13:0] ma;
  logic [4:0]  ra;

  always #5 clk = ~clk;

  crtc_timing #(.MA_WIDTH(14)) dut (
    .clk(clk), .reset(reset), .char_clk_en(char_clk_en),
    .h_total(h_total), .h_displayed(h_displayed), .h_sync_pos(h_sync_pos),
    .h_sync_width(h_sync_width), .v_sync_width(v_sync_width), .v_total(v_total),
    .v_line_adjust(v_line_adjust), .v_displayed(v_displayed), .v_sync_pos(v_sync_pos),
    .char_height(char_height), .start_addr(start_addr),
    .h_sync(h_sync), .v_sync(v_sync), .display_en(display_en), .ma(ma), .ra(ra),
    .frame_start(frame_start)
  );

  int n_chk = 0, n_pass = 0;

  // Model: absolute character/line counters and position within the frame.
  int m_started, m_h, m_line, m_abs_char, m_abs_line, m_hs_trig, m_vs_trig;
  bit m_fs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int lines_per_row();
    return int'(char_height) + 1;
  endfunction

  function automatic int active_lines();
    return (int'(v_total) + 1) * lines_per_row();
  endfunction

  task automatic locate(input int line, output int row, output int rr, output bit adj);
    if (line < active_lines()) begin
      row = line / lines_per_row(); rr = line % lines_per_row(); adj = 0;
    end else begin
      row = int'(v_total) + 1; rr = line - active_lines(); adj = 1;
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_h = 0; m_line = 0; m_abs_char = 0; m_abs_line = 0;
    m_hs_trig = -100000; m_vs_trig = -100000; m_fs = 0;
  endtask

  task automatic model_step();
    int row, rr; bit adj, nl;
    nl = 0;
    if (m_started == 0) begin
      m_started = 1; m_h = 0; m_line = 0; nl = 1; m_fs = 1;
    end else if (m_h == int'(h_total)) begin
      m_h = 0; m_line++; nl = 1;
      if (m_line >= active_lines() + int'(v_line_adjust)) begin m_line = 0; m_fs = 1; end
    end else begin
      m_h = (m_h + 1) % 256;
    end
    m_abs_char++;
    if (m_h == int'(h_sync_pos)) m_hs_trig = m_abs_char;
    if (nl) begin
      m_abs_line++;
      locate(m_line, row, rr, adj);
      if (!adj && row == int'(v_sync_pos) && rr == 0) m_vs_trig = m_abs_line;
    end
  endtask

  task automatic check_outputs();
    int row, rr, hw, vw; bit adj;
    logic e_hs, e_vs, e_de; logic [13:0] e_ma; logic [4:0] e_ra;
    if (m_started == 0) begin
      e_hs = 0; e_vs = 0; e_de = 0; e_ma = '0; e_ra = '0;
    end else begin
      locate(m_line, row, rr, adj);
      hw = (h_sync_width == 0) ? 16 : int'(h_sync_width);
      vw = (v_sync_width == 0) ? 16 : int'(v_sync_width);
      e_hs = (m_abs_char - m_hs_trig) < hw;
      e_vs = (m_abs_line - m_vs_trig) < vw;
      e_de = !adj && m_h < int'(h_displayed) && row < int'(v_displayed);
      e_ma = 14'((int'(start_addr) + row * int'(h_displayed) + m_h) % 16384);
      e_ra = 5'(rr);
    end
    chk("h_sync", h_sync, e_hs);
    chk("v_sync", v_sync, e_vs);
    chk("display_en", display_en, e_de);
    chk("ma", ma, e_ma);
    chk("ra", ra, e_ra);
    chk("frame_start", frame_start, m_fs);
  endtask

  task automatic cyc(input bit en, input bit rst);
    @(negedge clk);
    char_clk_en = en; reset = rst;
    if (rst) begin
      #1;
      chk("rst_async", {h_sync, v_sync, display_en, frame_start, ma, ra}, '0);
    end
    @(posedge clk); #1;
    m_fs = 0;
    if (rst) model_reset();
    else if (en) model_step();
    check_outputs();
  endtask

  task automatic set_pet();
    h_total = 63; h_displayed = 40; h_sync_pos = 48; h_sync_width = 4'h5; v_sync_width = 4'h1;
    v_total = 32; v_line_adjust = 0; v_displayed = 25; v_sync_pos = 28; char_height = 7;
    start_addr = 14'h0100;
  endtask

  initial begin
    int fs_seen, last_fs, vs_cnt, de_cnt, guard, len;
    logic [13:0] prev_ma;
    reset = 1; char_clk_en = 0;
    set_pet();
    model_reset();
    repeat (2) @(posedge clk);

    // PET defaults, two full frames.
    fs_seen = 0; last_fs = 0; vs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 2 * 16896 + 3; i++) begin
      cyc(1, 0);
      if (frame_start) begin
        if (fs_seen >= 1) begin
          chk("fs_period", i - last_fs, 16896);
          chk("vs_clks_per_frame", vs_cnt, 64);
          chk("de_clks_per_frame", de_cnt, 8000);
        end
        fs_seen++; last_fs = i; vs_cnt = 0; de_cnt = 0;
      end
      vs_cnt += v_sync; de_cnt += display_en;
    end
    chk("fs_count", fs_seen, 3);

    // Zero sync widths, then lower R0 below the running h_count on line 0.
    cyc(0, 1);
    h_sync_width = 0; v_sync_width = 0; v_sync_pos = 0; start_addr = 0; h_sync_pos = 2;
    guard = 0;
    do begin cyc(1, 0); guard++; end while (m_h != 20 && guard < 100);
    chk("reach_h20", guard < 100, 1);
    h_total = 10;
    prev_ma = ma; len = 0;
    do begin prev_ma = ma; cyc(1, 0); len++; end while (ma >= prev_ma && len < 400);
    chk("wrap_after_r0_write", len, 236);
    len = 0;
    do begin prev_ma = ma; cyc(1, 0); len++; end while (ma >= prev_ma && len < 400);
    chk("line_len_after_r0", len, 11);
    repeat (300) cyc(1, 0);

    // Adjust lines: 4 active + 3 adjust lines per frame.
    cyc(0, 1);
    set_pet();
    h_total = 9; h_displayed = 6; h_sync_pos = 7; v_total = 1; char_height = 1;
    v_line_adjust = 3; v_displayed = 2; v_sync_pos = 1; start_addr = 14'h3ffa;
    fs_seen = 0; last_fs = 0;
    for (int i = 0; i < 220; i++) begin
      cyc(1, 0);
      if (frame_start) begin
        if (fs_seen >= 1) chk("adj_period", i - last_fs, 70);
        fs_seen++; last_fs = i;
      end
    end
    for (int i = 0; i < 400; i++) cyc((i % 4) == 0, 0);
    // Mid-line reset under sparse strobes.
    cyc(0, 1);
    for (int i = 0; i < 200; i++) cyc((i % 4) == 0, 0);

    // Random configurations, strobe patterns and reset pulses.
    for (int c = 0; c < 10; c++) begin
      cyc(0, 1);
      h_total       = 8'($urandom_range(3, 20));
      h_displayed   = 8'($urandom_range(0, 22));
      h_sync_pos    = 8'($urandom_range(0, 21));
      h_sync_width  = 4'($urandom);
      v_sync_width  = 4'($urandom);
      v_total       = 7'($urandom_range(0, 4));
      v_line_adjust = 5'($urandom_range(0, 4));
      v_displayed   = 7'($urandom_range(0, 5));
      v_sync_pos    = 7'($urandom_range(0, 5));
      char_height   = 5'($urandom_range(0, 3));
      start_addr    = 14'($urandom);
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 499) == 0) cyc(0, 1);
        else cyc($urandom_range(0, 2) != 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
